// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential 8x8 shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    localparam int MUL_ITERS = 8;
    localparam int MUL_CNT_W = 3;
    localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_ITERS - 1);

endpackage

// File: rtl/adder_8.sv
// 8-bit Kogge-Stone carry-prefix adder, carry-in tied to zero.
module adder_8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [7:0] w_g0, w_p0;
    logic [7:0] w_g1, w_p1;
    logic [7:0] w_g2, w_p2;
    logic [7:0] w_g3;

    assign w_g0 = i_a & i_b;
    assign w_p0 = i_a ^ i_b;

    // Each level merges a bit with the group 1/2/4 below it; bits with no such group pass through.
    assign w_g1 = w_g0 | (w_p0 & (w_g0 << 1));
    assign w_p1 = w_p0 & ((w_p0 << 1) | 8'h01);
    assign w_g2 = w_g1 | (w_p1 & (w_g1 << 2));
    assign w_p2 = w_p1 & ((w_p1 << 2) | 8'h03);
    assign w_g3 = w_g2 | (w_p2 & (w_g2 << 4));

    assign o_sum  = w_p0 ^ {w_g3[6:0], 1'b0};
    assign o_cout = w_g3[7];

endmodule

// File: rtl/mul_8_seq.sv
// Multi-cycle unsigned 8x8->16 shift-add multiplier with valid/ready on both sides.
// state | meaning: IDLE accept operands | RUN one add-shift per cycle | DONE hold product until taken
module mul_8_seq
    import mul_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_product,
    output logic        o_ovf
);

    mul_state_t           r_state;
    logic [7:0]           r_mcand;
    logic [7:0]           r_mplier;
    logic [7:0]           r_acc_hi;
    logic [MUL_CNT_W-1:0] r_cnt;
    logic [15:0]          r_product;
    logic                 r_ovf;
    logic                 r_out_valid;

    logic [7:0]  w_addend;
    logic [7:0]  w_sum;
    logic        w_cout;
    logic [15:0] w_shifted;

    assign w_addend = r_mplier[0] ? r_mcand : 8'd0;

    adder_8 u_adder (
        .i_a    (r_acc_hi),
        .i_b    (w_addend),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Adder carry lands in bit 15 so the 17-bit {c,s,mplier} right shift never truncates.
    assign w_shifted = {w_cout, w_sum, r_mplier[7:1]};

    assign o_in_ready  = (r_state == IDLE) & ~i_rst;
    assign o_out_valid = r_out_valid;
    assign o_product   = r_product;
    assign o_ovf       = r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc_hi    <= '0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_mcand  <= i_a;
                        r_mplier <= i_b;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                        if (EARLY_EXIT && ((i_a == 8'd0) || (i_b == 8'd0))) begin
                            r_product <= '0;
                            r_ovf     <= 1'b0;
                            r_state   <= DONE;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_acc_hi <= w_shifted[15:8];
                    r_mplier <= w_shifted[7:0];
                    if (r_cnt == MUL_LAST) begin
                        r_product <= w_shifted;
                        r_ovf     <= |w_shifted[15:8];
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // out_valid trails entry to DONE by one cycle; the handshake only counts once it is up.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_8_seq.sv
// Self-checking bench for mul_8_seq: directed latency/backpressure/reset steps plus a randomized scoreboard run.
module tb_mul_8_seq;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, ovf;
    logic [7:0]  a, b;
    logic [15:0] product;
    logic        in_valid0, in_ready0, out_valid0, out_ready0, ovf0;
    logic [7:0]  a0, b0;
    logic [15:0] product0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mul_8_seq #(.EARLY_EXIT(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(a), .i_b(b), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_product(product), .o_ovf(ovf)
    );

    mul_8_seq #(.EARLY_EXIT(1'b0)) dut_full (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid0), .o_in_ready(in_ready0),
        .i_a(a0), .i_b(b0), .o_out_valid(out_valid0), .i_out_ready(out_ready0),
        .o_product(product0), .o_ovf(ovf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'(x) * int'(y);
        return p[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer operands until accepted; t is the cycle number of the accepting edge.
    task automatic accept(input logic [7:0] ta, input logic [7:0] tb_v, output int t);
        for (int k = 0; k < 50 && !in_ready; k++) step();
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        step();
        t = cyc;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic wait_valid(output int tv);
        for (int k = 0; k < 40 && !out_valid; k++) step();
        tv = cyc;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int t, tv, pulses, acc_n, done_n, guard;
        logic [15:0] q[$];
        logic [15:0] exp_p;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid0 = 1'b0; out_ready0 = 1'b0; a0 = '0; b0 = '0;
        step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        accept(8'd13, 8'd11, t);
        check("run_in_ready", in_ready, 0);
        wait_valid(tv);
        check("13x11_valid", out_valid, 1);
        check("13x11_latency", tv - t, 9);
        check("13x11_product", product, 16'h008F);
        check("13x11_ovf", ovf, 0);
        release_result();
        check("13x11_out_valid_drop", out_valid, 0);

        accept(8'd255, 8'd255, t);
        wait_valid(tv);
        check("255x255_latency", tv - t, 9);
        check("255x255_product", product, 16'hFE01);
        check("255x255_ovf", ovf, 1);
        // New operands offered in the same cycle as the result handshake must wait for IDLE.
        a = 8'd2; b = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("overlap_not_taken", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("overlap_taken_next", in_ready, 0);
        wait_valid(tv);
        check("2x3_product", product, ref_mul(8'd2, 8'd3));
        release_result();

        accept(8'd0, 8'd200, t);
        wait_valid(tv);
        check("zero_a_latency", tv - t, 1);
        check("zero_a_product", product, 0);
        release_result();
        accept(8'd5, 8'd0, t);
        wait_valid(tv);
        check("zero_b_latency", tv - t, 1);
        check("zero_b_product", product, 0);
        release_result();

        a0 = 8'd0; b0 = 8'd200; in_valid0 = 1'b1;
        step();
        t = cyc;
        in_valid0 = 1'b0;
        for (int k = 0; k < 40 && !out_valid0; k++) step();
        check("full_zero_valid", out_valid0, 1);
        check("full_zero_latency", cyc - t, 9);
        check("full_zero_product", product0, 0);
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
        check("full_zero_release", in_ready0, 1);

        accept(8'd16, 8'd16, t);
        wait_valid(tv);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_product", product, 16'h0100);
            check("bp_ovf", ovf, 1);
            check("bp_in_ready", in_ready, 0);
            step();
        end
        release_result();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);

        accept(8'd100, 8'd3, t);
        step(); step(); step();
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", in_ready, 0);
        step();
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_product", product, 0);
        check("rst_mid_ovf", ovf, 0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) pulses++;
            step();
        end
        check("rst_mid_no_pulse", pulses, 0);
        accept(8'd7, 8'd6, t);
        wait_valid(tv);
        check("7x6_latency", tv - t, 9);
        check("7x6_product", product, 16'h002A);
        check("7x6_ovf", ovf, 0);
        release_result();

        acc_n = 0; done_n = 0; guard = 0;
        while ((acc_n < 1000 || q.size() != 0) && guard < 40000) begin
            in_valid  = (acc_n < 1000) && ($urandom_range(0, 2) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                q.push_back(ref_mul(a, b));
                acc_n++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_result", out_valid, 0);
                end else begin
                    exp_p = q.pop_front();
                    check("rnd_product", product, exp_p);
                    check("rnd_ovf", ovf, (exp_p[15:8] != 8'd0));
                    done_n++;
                end
            end
            step();
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rnd_results_taken", done_n, 1000);
        check("rnd_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
